// File: rtl/pong_frame_renderer_if.sv
// Video-path bundle between the timing generator / game logic and the pong renderer.
// The master side drives counters, positions and scores; the slave side returns the pixel colour.
interface pong_frame_renderer_if #(
  parameter int SCORE_W = 7
);
  logic [10:0]        h_cnt;
  logic [10:0]        v_cnt;
  logic [SCORE_W-1:0] l_score;
  logic [SCORE_W-1:0] r_score;
  logic               game_over;
  logic [10:0]        h_ball_position;
  logic [10:0]        v_ball_position;
  logic [10:0]        l_paddle_position;
  logic [10:0]        r_paddle_position;
  logic [7:0]         red;
  logic [7:0]         green;
  logic [7:0]         blue;

  modport master (
    output h_cnt, v_cnt, l_score, r_score, game_over,
    output h_ball_position, v_ball_position, l_paddle_position, r_paddle_position,
    input  red, green, blue
  );

  modport slave (
    input  h_cnt, v_cnt, l_score, r_score, game_over,
    input  h_ball_position, v_ball_position, l_paddle_position, r_paddle_position,
    output red, green, blue
  );
endinterface

// File: rtl/pong_frame_renderer.sv
// Two-stage pong pixel renderer: per-frame snapshot of positions/scores, sequential
// double-dabble score conversion, multi-digit 3x5 glyphs with game-over blinking.
module pong_frame_renderer #(
  parameter int SCR_W      = 1280,
  parameter int SCR_H      = 720,
  parameter int BALL_W     = 8,
  parameter int BALL_H     = 8,
  parameter int PADDLE_W   = 4,
  parameter int PADDLE_H   = 64,
  parameter int PADDLE_X   = 8,
  parameter int SCORE_W    = 7,
  parameter int NUM_DIGITS = 2,
  parameter int SEG_PX     = 4,
  parameter int SCORE_Y    = 16,
  parameter int BLINK_LOG2 = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  pong_frame_renderer_if.slave vid
);

  localparam int BCD_N     = (SCORE_W + 2) / 3;
  localparam int WIDE_N    = (BCD_N > NUM_DIGITS) ? BCD_N : NUM_DIGITS;
  localparam int MAX_SCORE = (NUM_DIGITS == 1) ? 9 : (NUM_DIGITS == 2) ? 99 : 999;
  localparam int CNT_W     = $clog2(SCORE_W) + 1;
  localparam int FC_W      = BLINK_LOG2 + 1;
  localparam int LX0       = SCR_W / 4;
  localparam int RX0       = 3 * SCR_W / 4;
  localparam int RPAD_X    = SCR_W - PADDLE_X - PADDLE_W;
  localparam int PITCH     = 4 * SEG_PX;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} bcd_state_t;

  function automatic logic in_span(input logic [11:0] p, input logic [11:0] lo,
                                   input logic [11:0] len);
    return (p >= lo) && (p < lo + len);
  endfunction

  function automatic logic [4*BCD_N-1:0] add3(input logic [4*BCD_N-1:0] bcd);
    add3 = bcd;
    for (int k = 0; k < BCD_N; k++)
      if (bcd[4*k+:4] >= 4'd5) add3[4*k+:4] = bcd[4*k+:4] + 4'd3;
  endfunction

  function automatic logic [4*NUM_DIGITS-1:0] sat_digits(input logic [4*BCD_N-1:0] bcd,
                                                         input logic [SCORE_W-1:0] score);
    logic [4*WIDE_N-1:0] wide;
    wide = (4*WIDE_N)'(bcd);
    if (32'(score) > MAX_SCORE) sat_digits = {NUM_DIGITS{4'd9}};
    else                        sat_digits = wide[4*NUM_DIGITS-1:0];
  endfunction

  function automatic logic [NUM_DIGITS-1:0] shown_mask(input logic [4*NUM_DIGITS-1:0] dig);
    logic nz;
    nz = 1'b0;
    shown_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz = nz | (dig[4*k+:4] != 4'd0);
      shown_mask[k] = nz | (k == 0);
    end
  endfunction

  // Segment order {a,b,c,d,e,f,g}: top, right-top, right-bottom, bottom, left-bottom, left-top, middle.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  function automatic logic cell_lit(input logic [6:0] s, input int c, input int r);
    return (r == 0 && s[6]) || (r == 2 && s[0]) || (r == 4 && s[3]) ||
           (c == 0 && r <= 2 && s[1]) || (c == 2 && r <= 2 && s[5]) ||
           (c == 0 && r >= 2 && s[2]) || (c == 2 && r >= 2 && s[4]);
  endfunction

  function automatic logic [23:0] pick_rgb(input logic border, input logic ball,
                                           input logic paddle, input logic score);
    if (border)      pick_rgb = 24'hFFFFFF;
    else if (ball)   pick_rgb = 24'h0000FF;
    else if (paddle) pick_rgb = 24'hFF0000;
    else if (score)  pick_rgb = 24'hFFFFFF;
    else             pick_rgb = 24'h000000;
  endfunction

  logic [11:0] h12, v12;
  logic        snap;
  assign h12  = {1'b0, vid.h_cnt};
  assign v12  = {1'b0, vid.v_cnt};
  assign snap = (vid.h_cnt == '0) && (vid.v_cnt == '0);

  logic [10:0]        hb_s, vb_s, lp_s, rp_s;
  logic [SCORE_W-1:0] ls_s, rs_s;
  logic               go_s;
  logic [FC_W-1:0]    frame_cnt, frame_nxt;
  assign frame_nxt = frame_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_s <= '0; vb_s <= '0; lp_s <= '0; rp_s <= '0;
      ls_s <= '0; rs_s <= '0; go_s <= 1'b0; frame_cnt <= '0;
    end else if (snap) begin
      hb_s      <= vid.h_ball_position;
      vb_s      <= vid.v_ball_position;
      lp_s      <= vid.l_paddle_position;
      rp_s      <= vid.r_paddle_position;
      ls_s      <= vid.l_score;
      rs_s      <= vid.r_score;
      go_s      <= vid.game_over;
      frame_cnt <= frame_nxt;
    end
  end

  // The snapshot pixel itself must already see the freshly latched frame state.
  logic [10:0] hb_e, vb_e, lp_e, rp_e;
  logic        go_e, blink_off;
  assign hb_e      = snap ? vid.h_ball_position   : hb_s;
  assign vb_e      = snap ? vid.v_ball_position   : vb_s;
  assign lp_e      = snap ? vid.l_paddle_position : lp_s;
  assign rp_e      = snap ? vid.r_paddle_position : rp_s;
  assign go_e      = snap ? vid.game_over         : go_s;
  assign blink_off = snap ? frame_nxt[BLINK_LOG2] : frame_cnt[BLINK_LOG2];

  bcd_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             conv_en, load_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (snap)         cnt <= '0;
      else if (conv_en) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    conv_en   = 1'b0;
    load_en   = 1'b0;
    case (state)
      IDLE: state_nxt = IDLE;
      CONV: begin
        conv_en = 1'b1;
        if (cnt == CNT_W'(SCORE_W - 1)) state_nxt = LOAD;
      end
      LOAD: begin
        load_en   = ~snap;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (snap) state_nxt = CONV;
  end

  logic [SCORE_W-1:0]         l_bin, r_bin;
  logic [4*BCD_N-1:0]         l_bcd, r_bcd;
  logic [4*BCD_N+SCORE_W-1:0] l_sh, r_sh;

  always_comb begin
    l_sh = {add3(l_bcd), l_bin} << 1;
    r_sh = {add3(r_bcd), r_bin} << 1;
  end

  always_ff @(posedge clk) begin
    if (snap) begin
      l_bin <= vid.l_score;
      r_bin <= vid.r_score;
      l_bcd <= '0;
      r_bcd <= '0;
    end else if (conv_en) begin
      l_bcd <= l_sh[4*BCD_N+SCORE_W-1:SCORE_W];
      r_bcd <= r_sh[4*BCD_N+SCORE_W-1:SCORE_W];
      l_bin <= l_sh[SCORE_W-1:0];
      r_bin <= r_sh[SCORE_W-1:0];
    end
  end

  // Both sides commit in the same cycle so a frame never shows a half-updated score.
  logic [4*NUM_DIGITS-1:0] l_dig, r_dig;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_dig <= '0;
      r_dig <= '0;
    end else if (load_en) begin
      l_dig <= sat_digits(l_bcd, ls_s);
      r_dig <= sat_digits(r_bcd, rs_s);
    end
  end

  logic [NUM_DIGITS-1:0] l_show, r_show;
  assign l_show = shown_mask(l_dig);
  assign r_show = shown_mask(r_dig);

  logic in_range, border_hit, ball_hit, paddle_hit, score_hit, glyph_hit;
  always_comb begin
    glyph_hit = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 5; r++) begin
          if (in_span(v12, 12'(SCORE_Y + r * SEG_PX), 12'(SEG_PX))) begin
            if (in_span(h12, 12'(LX0 + d * PITCH + c * SEG_PX), 12'(SEG_PX)) &&
                l_show[NUM_DIGITS-1-d] &&
                cell_lit(seg7(l_dig[4*(NUM_DIGITS-1-d)+:4]), c, r))
              glyph_hit = 1'b1;
            if (in_span(h12, 12'(RX0 + d * PITCH + c * SEG_PX), 12'(SEG_PX)) &&
                r_show[NUM_DIGITS-1-d] &&
                cell_lit(seg7(r_dig[4*(NUM_DIGITS-1-d)+:4]), c, r))
              glyph_hit = 1'b1;
          end
        end
      end
    end
    in_range   = (h12 < 12'(SCR_W)) && (v12 < 12'(SCR_H));
    border_hit = in_range && ((h12 == 12'd0) || (v12 == 12'd0) ||
                              (h12 == 12'(SCR_W - 1)) || (v12 == 12'(SCR_H - 1)));
    ball_hit   = in_range && !go_e &&
                 in_span(h12, {1'b0, hb_e}, 12'(BALL_W)) &&
                 in_span(v12, {1'b0, vb_e}, 12'(BALL_H));
    paddle_hit = in_range &&
                 ((in_span(h12, 12'(PADDLE_X), 12'(PADDLE_W)) &&
                   in_span(v12, {1'b0, lp_e}, 12'(PADDLE_H))) ||
                  (in_span(h12, 12'(RPAD_X), 12'(PADDLE_W)) &&
                   in_span(v12, {1'b0, rp_e}, 12'(PADDLE_H))));
    score_hit  = in_range && glyph_hit && (!go_e || !blink_off);
  end

  // Stage 1: per-object hit flags
  logic border_p1, ball_p1, paddle_p1, score_p1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      border_p1 <= 1'b0; ball_p1 <= 1'b0; paddle_p1 <= 1'b0; score_p1 <= 1'b0;
    end else begin
      border_p1 <= border_hit;
      ball_p1   <= ball_hit;
      paddle_p1 <= paddle_hit;
      score_p1  <= score_hit;
    end
  end

  // Stage 2: prioritised colour
  logic [23:0] rgb_p2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_p2 <= '0;
    else        rgb_p2 <= pick_rgb(border_p1, ball_p1, paddle_p1, score_p1);
  end

  assign vid.red   = rgb_p2[23:16];
  assign vid.green = rgb_p2[15:8];
  assign vid.blue  = rgb_p2[7:0];

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer: pixels are driven straight onto the counters and
// the colour is checked two clocks later against hand-derived values.
module tb_pong_frame_renderer;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] BLACK = 24'h000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pong_frame_renderer_if #(.SCORE_W(7)) vid();

  pong_frame_renderer #(
    .SCR_W(1280), .SCR_H(720), .BALL_W(8), .BALL_H(8), .PADDLE_W(4), .PADDLE_H(64),
    .PADDLE_X(8), .SCORE_W(7), .NUM_DIGITS(2), .SEG_PX(4), .SCORE_Y(16), .BLINK_LOG2(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vid  (vid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic blink_on [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic cmp(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic park();
    vid.h_cnt = 11'd1500;
    vid.v_cnt = 11'd700;
  endtask

  task automatic px(input string tag, input int h, input int v, input logic [23:0] exp);
    vid.h_cnt = 11'(h);
    vid.v_cnt = 11'(v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp(tag, {vid.red, vid.green, vid.blue}, exp);
  endtask

  task automatic snapshot();
    vid.h_cnt = 11'd0;
    vid.v_cnt = 11'd0;
    @(posedge clk);
    #1;
    park();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    vid.h_ball_position   = 11'd100;
    vid.v_ball_position   = 11'd50;
    vid.l_paddle_position = 11'd200;
    vid.r_paddle_position = 11'd300;
    vid.l_score           = 7'd47;
    vid.r_score           = 7'd5;
    vid.game_over         = 1'b0;
    park();

    // Reset state: black output, both sides show a single "0" before any snapshot.
    repeat (2) @(negedge clk);
    cmp("reset_rgb", {vid.red, vid.green, vid.blue}, BLACK);
    rst_n = 1'b1;
    px("rst_l_lsd_top",   336, 16, WHITE);
    px("rst_l_lsd_bot",   336, 32, WHITE);
    px("rst_l_msd_blank", 320, 16, BLACK);
    px("rst_r_lsd_top",   976, 16, WHITE);
    px("border_top",        5,  0, WHITE);
    #2 rst_n = 1'b0;
    #1 cmp("async_reset", {vid.red, vid.green, vid.blue}, BLACK);
    @(negedge clk);
    rst_n = 1'b1;

    // Digit regs change on the 8th edge after the snapshot edge.
    vid.h_cnt = 11'd0;
    vid.v_cnt = 11'd0;
    @(posedge clk);
    #1;
    vid.h_cnt = 11'd336;
    vid.v_cnt = 11'd32;
    repeat (9) @(posedge clk);
    @(negedge clk);
    cmp("bcd_before_load", {vid.red, vid.green, vid.blue}, WHITE);
    @(negedge clk);
    cmp("bcd_after_load", {vid.red, vid.green, vid.blue}, BLACK);

    px("ball_left_out", 99, 50, BLACK);
    vid.h_cnt = 11'd100;
    vid.v_cnt = 11'd50;
    @(posedge clk);
    @(negedge clk);
    cmp("latency_1clk", {vid.red, vid.green, vid.blue}, BLACK);
    @(posedge clk);
    @(negedge clk);
    cmp("latency_2clk", {vid.red, vid.green, vid.blue}, BLUE);
    px("ball_corner",     107,  57, BLUE);
    px("ball_right_edge", 108,  50, BLACK);
    px("ball_bot_edge",   100,  58, BLACK);
    px("lpad_top",          8, 200, RED);
    px("lpad_corner",      11, 263, RED);
    px("lpad_right_out",   12, 200, BLACK);
    px("lpad_bot_out",      8, 264, BLACK);
    px("rpad_top",       1271, 300, RED);
    px("rpad_above",     1268, 299, BLACK);
    px("border_right",   1279,   5, WHITE);
    px("border_bottom",     5, 719, WHITE);
    px("blank_h",        1280,   5, BLACK);
    px("blank_v",           5, 720, BLACK);
    px("l4_lefttop",      320,  16, WHITE);
    px("l4_top_off",      324,  16, BLACK);
    px("l4_middle",       324,  24, WHITE);
    px("l7_top",          340,  16, WHITE);
    px("l7_middle_off",   340,  24, BLACK);
    px("l7_rightbot",     344,  32, WHITE);
    px("r_msd_blank",     964,  16, BLACK);
    px("r5_righttop_off", 984,  20, BLACK);
    px("r5_lefttop",      976,  20, WHITE);
    px("r5_rightbot",     984,  28, WHITE);
    px("r5_leftbot_off",  976,  28, BLACK);

    // Mid-frame input change is invisible until the next snapshot.
    vid.h_ball_position = 11'd300;
    px("midframe_old", 100, 50, BLUE);
    px("midframe_new", 300, 50, BLACK);
    snapshot();
    px("nextframe_new", 300, 50, BLUE);
    px("nextframe_old", 100, 50, BLACK);

    // Restart during conversion, then saturation of 120 to "99".
    vid.r_score = 7'd33;
    snapshot();
    repeat (2) @(posedge clk);
    #1;
    vid.r_score = 7'd120;
    snapshot();
    repeat (12) @(posedge clk);
    #1;
    px("sat_msd_lefttop", 960, 20, WHITE);
    px("sat_lsd_lefttop", 976, 20, WHITE);
    px("sat_lsd_bottom",  980, 32, WHITE);
    px("sat_left_kept",   324, 24, WHITE);

    // Game over with 2-frame blink half-period.
    vid.game_over       = 1'b1;
    vid.h_ball_position = 11'd100;
    snapshot();
    px("go_ball_absent", 100, 50, BLACK);
    px("go_lpad",          8, 200, RED);
    px("go_rpad",       1271, 300, RED);
    px("go_border",        5,   0, WHITE);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) snapshot();
      px($sformatf("blink_f%0d", i), 340, 16, blink_on[i] ? WHITE : BLACK);
    end

    // Ball outranks paddle where they overlap.
    vid.game_over         = 1'b0;
    vid.h_ball_position   = 11'd8;
    vid.v_ball_position   = 11'd200;
    snapshot();
    px("prio_ball_on_pad", 8, 200, BLUE);
    px("prio_ball_only",  12, 200, BLUE);
    px("prio_none",       16, 200, BLACK);
    px("prio_pad_below",   8, 208, RED);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
